parallel_to_serial_tx: RTL
==========================

PARALLEL_TO_SERIAL_TX -- requirements
Module: parallel_to_serial_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port d_in, input, WIDTH bits: parallel word to transmit.
REQ-006 The block SHALL have port load_valid, input, 1 bit: d_in is valid.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block can accept d_in this cycle.
REQ-008 The block SHALL have port ser_out, output, 1 bit: current serial data bit.
REQ-009 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a valid bit.
REQ-010 The block SHALL have port ser_ready, input, 1 bit: the downstream receiver accepts ser_out this cycle.
REQ-011 The block SHALL have port frame_start, output, 1 bit: high while the first bit of a word is presented.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when the last bit of a word is accepted.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-014 A load SHALL occur on a rising edge with load_valid=1 and load_ready=1; the word is captured into an internal shift register and the bit counter is cleared.
REQ-015 A load SHALL move the FSM to SHIFT; the first bit SHALL appear on ser_out with ser_valid=1 in the cycle immediately after the load edge (latency 1).
REQ-016 A bit transfer SHALL occur on a rising edge with ser_valid=1 and ser_ready=1; the shift register then advances one bit and the counter increments.
REQ-017 With ser_ready=0, ser_out, ser_valid, frame_start and the counter SHALL hold unchanged (stall, unlimited length).
REQ-018 ser_valid SHALL be 1 in SHIFT and 0 in IDLE; ser_out SHALL be 0 in IDLE.
REQ-019 frame_start SHALL be 1 only while in SHIFT with the counter at 0.
REQ-020 The last bit SHALL be the one presented when the counter equals WIDTH-1.
REQ-021 done SHALL be asserted combinationally in the cycle in which the last bit transfer occurs (ser_valid=1, ser_ready=1, last bit).
REQ-022 load_ready SHALL equal (state==IDLE) OR (state==SHIFT AND last bit AND ser_ready); this combinational path from ser_ready to load_ready is intentional.
REQ-023 When a last-bit transfer and a load occur on the same edge, the new word SHALL start with no idle gap (back-to-back), and the FSM SHALL stay in SHIFT.
REQ-024 When a last-bit transfer occurs without a load, the FSM SHALL return to IDLE.
REQ-025 When load_ready=0, d_in and load_valid SHALL be ignored; the word in flight SHALL not be corrupted.

Reset
REQ-026 While reset=0, the FSM SHALL be IDLE, the counter and shift register 0, ser_out=0, ser_valid=0, frame_start=0, done=0 and load_ready=1 (no capture is possible while reset is held).
REQ-027 A reset assertion during SHIFT SHALL abort the word immediately; no partial done pulse SHALL be generated.
REQ-028 The first load SHALL be accepted on the first rising edge after reset deassertion.

Structure
REQ-029 A shared package shift_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the constant DEFAULT_WIDTH=4.
REQ-030 The bit counter SHALL be a sub-module named bit_counter, with parameter WIDTH, inputs clr and inc, and outputs count and last.
REQ-031 Counter width SHALL be $clog2(WIDTH) bits; the counter SHALL never wrap past WIDTH-1.

Verification
REQ-032 Scenario 1: WIDTH=4, MSB_FIRST=1, load 4'b1011, ser_ready=1 -> ser_out 1,0,1,1 on cycles 1-4 after the load; frame_start in cycle 1; done in cycle 4; IDLE in cycle 5.
REQ-033 Scenario 2: MSB_FIRST=0, load 4'b1011 -> ser_out 1,1,0,1.
REQ-034 Scenario 3: load 4'b1100, ser_ready=0 for 3 cycles after bit 1 -> ser_out holds 1 and ser_valid holds 1; the remaining bits then follow unchanged and exactly one done pulse occurs.
REQ-035 Scenario 4: back-to-back loads 4'b1010 then 4'b0110 with load_valid=1 held -> 8 contiguous bits 1,0,1,0,0,1,1,0; frame_start on bits 1 and 5; done on bits 4 and 8.
REQ-036 Scenario 5: load_valid pulsed with 4'b1111 during bit 2 of word 4'b0000 -> ignored; output 0,0,0,0.
REQ-037 Scenario 6: reset asserted during bit 3 -> ser_valid=0 and ser_out=0 immediately, done never asserted; the next load after release transmits correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
// FSM encoding and default word width.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/parallel_to_serial_tx_bit_counter.sv
// Bit position counter for the serializer.
// Saturates at WIDTH-1; clr has priority over inc.
module bit_counter #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parallel_to_serial_tx.sv
// Parallel word to serial bit stream with valid/ready on both sides.
// Supports back-to-back words with no idle gap.
module parallel_to_serial_tx
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             last;
  logic             in_shift;
  logic             head;
  logic             xfer;
  logic             load;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load | done),
    .inc   (xfer),
    .count (count),
    .last  (last)
  );

  assign head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  always_comb begin
    state_nxt   = state;
    in_shift    = (state == SHIFT);
    ser_valid   = in_shift;
    ser_out     = in_shift & head;
    frame_start = in_shift && (count == '0);
    xfer        = ser_valid & ser_ready;
    done        = xfer & last;
    // ser_ready feeds load_ready so a new word can follow the last bit
    load_ready  = !in_shift | (last & ser_ready);
    load        = load_valid & load_ready;
    unique case (state)
      IDLE:  if (load) state_nxt = SHIFT;
      SHIFT: if (done && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= d_in;
    end else if (xfer) begin
      sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    end
  end

endmodule
